// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the internal memory port: round-robin ownership with a
// burst cap, combinational access issue and an owner-tagged read-return pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_rd,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cmd_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    HOST = 2'd2
  } owner_t;

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BURST - 1);

  owner_t owner, owner_next;
  owner_t last_owner, last_owner_next;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_next;
  logic [MEM_LAT-1:0] pipe_valid;
  logic [MEM_LAT-1:0] pipe_tag;

  logic issue;
  logic sel_rd;
  logic sel_wr;
  logic rd_push;

  // Owner's command drives the memory port; rd&wr together is downgraded to a write.
  always_comb begin
    issue     = 1'b0;
    sel_rd    = 1'b0;
    sel_wr    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    case (owner)
      CPU: begin
        if (cpu_req) begin
          issue     = 1'b1;
          sel_rd    = cpu_rd;
          sel_wr    = cpu_wr;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end else begin
          issue = 1'b0;
        end
      end
      HOST: begin
        if (host_req) begin
          issue     = 1'b1;
          sel_rd    = host_rd;
          sel_wr    = host_wr;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end else begin
          issue = 1'b0;
        end
      end
      default: issue = 1'b0;
    endcase
    mem_wr  = sel_wr;
    mem_rd  = sel_rd & ~sel_wr;
    rd_push = issue & sel_rd & ~sel_wr;
  end

  // Ownership next-state: handoff without bubble, burst cap only when the other waits.
  always_comb begin
    owner_next      = owner;
    last_owner_next = last_owner;
    case (owner)
      IDLE: begin
        if (cpu_req && host_req) begin
          owner_next = (last_owner == CPU) ? HOST : CPU;
        end else if (cpu_req) begin
          owner_next = CPU;
        end else if (host_req) begin
          owner_next = HOST;
        end else begin
          owner_next = IDLE;
        end
      end
      CPU: begin
        if (!cpu_req) begin
          owner_next = host_req ? HOST : IDLE;
        end else if (host_req && burst_cnt == CAP) begin
          owner_next = HOST;
        end else begin
          owner_next = CPU;
        end
      end
      HOST: begin
        if (!host_req) begin
          owner_next = cpu_req ? CPU : IDLE;
        end else if (cpu_req && burst_cnt == CAP) begin
          owner_next = CPU;
        end else begin
          owner_next = HOST;
        end
      end
      default: owner_next = IDLE;
    endcase
    if (owner != IDLE && owner_next != owner) begin
      last_owner_next = owner;
    end else begin
      last_owner_next = last_owner;
    end
    if (owner_next != owner) begin
      burst_cnt_next = {CNT_W{1'b0}};
    end else if (issue && burst_cnt != CAP) begin
      burst_cnt_next = burst_cnt + CNT_W'(1);
    end else begin
      burst_cnt_next = burst_cnt;
    end
  end

  // Ownership, grant, burst and sticky error state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= IDLE;
      last_owner <= HOST;
      burst_cnt  <= {CNT_W{1'b0}};
      cpu_gnt    <= 1'b0;
      host_gnt   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      owner      <= owner_next;
      last_owner <= last_owner_next;
      burst_cnt  <= burst_cnt_next;
      cpu_gnt    <= (owner_next == CPU);
      host_gnt   <= (owner_next == HOST);
      cmd_err    <= cmd_err | (issue & sel_rd & sel_wr);
    end
  end

  // Read-return shift register; tag 1 marks a host read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= {MEM_LAT{1'b0}};
      pipe_tag   <= {MEM_LAT{1'b0}};
    end else begin
      pipe_valid[0] <= rd_push;
      pipe_tag[0]   <= (owner == HOST);
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
      end
    end
  end

  assign cpu_rvalid  = pipe_valid[MEM_LAT-1] & ~pipe_tag[MEM_LAT-1];
  assign host_rvalid = pipe_valid[MEM_LAT-1] &  pipe_tag[MEM_LAT-1];
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : {DATA_W{1'b0}};
  assign host_rdata  = host_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 ns after posedge, outputs
// are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_rd, cpu_wr;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_gnt, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       host_req, host_rd, host_wr;
  logic [4:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(5), .DATA_W(8), .MAX_BURST(4), .MEM_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_rd(host_rd), .host_wr(host_wr),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cmd_err(cmd_err)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_cpu(input logic req, input logic rd, input logic wr,
                         input logic [4:0] addr, input logic [7:0] wdata);
    cpu_req = req; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic set_host(input logic req, input logic rd, input logic wr,
                          input logic [4:0] addr, input logic [7:0] wdata);
    host_req = req; host_rd = rd; host_wr = wr; host_addr = addr; host_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_rdata = 8'h00;
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("rst_cpu_gnt",  32'(cpu_gnt),  32'h0);
    check_val("rst_host_gnt", 32'(host_gnt), 32'h0);
    check_val("rst_mem_rd",   32'(mem_rd),   32'h0);
    check_val("rst_mem_wr",   32'(mem_wr),   32'h0);
    check_val("rst_cmd_err",  32'(cmd_err),  32'h0);
    tick();
    rst = 1'b0;

    // CPU-only read with 1-cycle memory latency
    mem_rdata = 8'hA5;
    set_cpu(1'b1, 1'b1, 1'b0, 5'h03, 8'h00);
    sample();
    check_val("c2_idle_gnt", 32'(cpu_gnt), 32'h0);
    check_val("c2_idle_rd",  32'(mem_rd),  32'h0);
    tick();
    sample();
    check_val("c2_gnt",  32'(cpu_gnt),  32'h1);
    check_val("c2_rd",   32'(mem_rd),   32'h1);
    check_val("c2_addr", 32'(mem_addr), 32'h03);
    tick();
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c2_rvalid",  32'(cpu_rvalid),  32'h1);
    check_val("c2_rdata",   32'(cpu_rdata),   32'hA5);
    check_val("c2_hrvalid", 32'(host_rvalid), 32'h0);
    check_val("c2_noissue", 32'(mem_rd),      32'h0);
    tick();
    sample();
    check_val("c2_rvalid_end", 32'(cpu_rvalid), 32'h0);
    check_val("c2_rdata_end",  32'(cpu_rdata),  32'h00);
    check_val("c2_gnt_end",    32'(cpu_gnt),    32'h0);

    // Reset with a read in flight
    set_cpu(1'b1, 1'b1, 1'b0, 5'h04, 8'h00);
    tick();
    sample();
    check_val("c1_gnt", 32'(cpu_gnt), 32'h1);
    check_val("c1_rd",  32'(mem_rd),  32'h1);
    tick();
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c1_rst_rvalid", 32'(cpu_rvalid), 32'h0);
    check_val("c1_rst_rdata",  32'(cpu_rdata),  32'h00);
    check_val("c1_rst_gnt",    32'(cpu_gnt),    32'h0);
    check_val("c1_rst_addr",   32'(mem_addr),   32'h00);
    tick();
    rst = 1'b0;
    sample();
    check_val("c1_post_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();

    // Ties from IDLE alternate, CPU first after reset
    set_cpu(1'b1, 1'b0, 1'b1, 5'h01, 8'h01);
    set_host(1'b1, 1'b0, 1'b1, 5'h02, 8'h02);
    tick();
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c3_tie1_cpu",  32'(cpu_gnt),  32'h1);
    check_val("c3_tie1_host", 32'(host_gnt), 32'h0);
    tick();
    set_cpu(1'b1, 1'b0, 1'b1, 5'h01, 8'h01);
    set_host(1'b1, 1'b0, 1'b1, 5'h02, 8'h02);
    tick();
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c3_tie2_cpu",  32'(cpu_gnt),  32'h0);
    check_val("c3_tie2_host", 32'(host_gnt), 32'h1);
    tick();

    // Burst cap of 4 with both requesting continuously
    set_cpu(1'b1, 1'b0, 1'b1, 5'h0A, 8'h11);
    set_host(1'b1, 1'b0, 1'b1, 5'h15, 8'h22);
    tick();
    for (int k = 1; k <= 9; k++) begin
      logic exp_cpu;
      exp_cpu = (k <= 4) || (k == 9);
      sample();
      check_val($sformatf("c4_cpu_gnt_%0d", k),  32'(cpu_gnt),  32'(exp_cpu));
      check_val($sformatf("c4_host_gnt_%0d", k), 32'(host_gnt), 32'(!exp_cpu));
      check_val($sformatf("c4_wr_%0d", k),       32'(mem_wr),   32'h1);
      check_val($sformatf("c4_addr_%0d", k),     32'(mem_addr), exp_cpu ? 32'h0A : 32'h15);
      check_val($sformatf("c4_wdata_%0d", k),    32'(mem_wdata), exp_cpu ? 32'h11 : 32'h22);
      tick();
    end
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c4_drop_wr", 32'(mem_wr), 32'h0);
    tick();

    // CPU read in last burst slot returns after the switch to HOST
    mem_rdata = 8'hC7;
    set_cpu(1'b1, 1'b1, 1'b0, 5'h02, 8'h00);
    tick();
    set_host(1'b1, 1'b0, 1'b1, 5'h08, 8'h44);
    for (int k = 1; k <= 4; k++) begin
      sample();
      check_val($sformatf("c5_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'h1);
      check_val($sformatf("c5_rd_%0d", k),      32'(mem_rd),  32'h1);
      tick();
    end
    sample();
    check_val("c5_host_gnt", 32'(host_gnt),    32'h1);
    check_val("c5_cpu_gnt",  32'(cpu_gnt),     32'h0);
    check_val("c5_rvalid",   32'(cpu_rvalid),  32'h1);
    check_val("c5_rdata",    32'(cpu_rdata),   32'hC7);
    check_val("c5_hrvalid",  32'(host_rvalid), 32'h0);
    check_val("c5_host_wr",  32'(mem_wr),      32'h1);
    tick();
    set_cpu(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c5_rvalid_end", 32'(cpu_rvalid), 32'h0);
    tick();

    // Host read return
    mem_rdata = 8'h5A;
    set_host(1'b1, 1'b1, 1'b0, 5'h07, 8'h00);
    tick();
    sample();
    check_val("h_gnt",  32'(host_gnt), 32'h1);
    check_val("h_rd",   32'(mem_rd),   32'h1);
    check_val("h_addr", 32'(mem_addr), 32'h07);
    tick();
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("h_rvalid",  32'(host_rvalid), 32'h1);
    check_val("h_rdata",   32'(host_rdata),  32'h5A);
    check_val("h_crvalid", 32'(cpu_rvalid),  32'h0);
    check_val("h_crdata",  32'(cpu_rdata),   32'h00);
    tick();

    // rd&wr together: write only, sticky error until reset
    set_host(1'b1, 1'b1, 1'b1, 5'h1F, 8'h3C);
    tick();
    sample();
    check_val("c6_wr",      32'(mem_wr),    32'h1);
    check_val("c6_rd",      32'(mem_rd),    32'h0);
    check_val("c6_addr",    32'(mem_addr),  32'h1F);
    check_val("c6_wdata",   32'(mem_wdata), 32'h3C);
    check_val("c6_err_pre", 32'(cmd_err),   32'h0);
    tick();
    set_host(1'b0, 1'b0, 1'b0, 5'h00, 8'h00);
    sample();
    check_val("c6_err_set", 32'(cmd_err),     32'h1);
    check_val("c6_hrvalid", 32'(host_rvalid), 32'h0);
    tick();
    sample();
    check_val("c6_err_hold", 32'(cmd_err), 32'h1);
    tick();
    rst = 1'b1;
    sample();
    check_val("c6_err_rst", 32'(cmd_err), 32'h0);
    tick();
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
